// File: rtl/n_clic_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : n_clic_arbiter_if
// Description : Bundle of signals between the CLIC entry CSRs / core and the
//               interrupt arbiter. The master modport is the arbiter side. The
//               slave modport is the CLIC + core side.
//   pended/enable/prio/thresh : per-vector CLIC entry fields and mintthresh
//   irq_ack/mret              : core acknowledge and handler-return pulse
//   irq_valid/irq_id/irq_prio : request presented to the core
//   pend_clr                  : one-hot pended-bit clear back to the CLIC
//   level/depth/stack_full    : nesting state, feeds the stack-depth CSR
// Revision    : 1.0 - initial release
// ============================================================================
interface n_clic_arbiter_if #(
  parameter int VecSize    = 8,
  parameter int PrioLevels = 8,
  parameter int StackDepth = 4
);
  localparam int VecWidth   = $clog2(VecSize);
  localparam int PrioWidth  = $clog2(PrioLevels);
  localparam int DepthWidth = $clog2(StackDepth + 1);

  logic [VecSize-1:0]           pended;
  logic [VecSize-1:0]           enable;
  logic [VecSize*PrioWidth-1:0] prio;
  logic [PrioWidth-1:0]         thresh;
  logic                         irq_ack;
  logic                         mret;
  logic                         irq_valid;
  logic [VecWidth-1:0]          irq_id;
  logic [PrioWidth-1:0]         irq_prio;
  logic [VecSize-1:0]           pend_clr;
  logic [PrioWidth-1:0]         level;
  logic [DepthWidth-1:0]        depth;
  logic                         stack_full;

  modport master (
    input  pended, enable, prio, thresh, irq_ack, mret,
    output irq_valid, irq_id, irq_prio, pend_clr, level, depth, stack_full
  );

  modport slave (
    output pended, enable, prio, thresh, irq_ack, mret,
    input  irq_valid, irq_id, irq_prio, pend_clr, level, depth, stack_full
  );
endinterface
`default_nettype wire

// File: rtl/n_clic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : n_clic_arbiter
// Description : Interrupt arbitration and nesting stage behind the CLIC.
//               It picks the highest-priority eligible vector, with ties going
//               to the lowest index. It presents that vector to the core over
//               a valid/ack handshake. An ack pushes the running level onto
//               the preemption stack. An mret pops the stack.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : n_clic_arbiter_if.master (CLIC fields in, request/nesting out)
// Revision    : 1.0 - initial release
// ============================================================================
module n_clic_arbiter #(
  parameter int VecSize    = 8,
  parameter int PrioLevels = 8,
  parameter int StackDepth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  n_clic_arbiter_if.master        bus
);
  localparam int VecWidth   = $clog2(VecSize);
  localparam int PrioWidth  = $clog2(PrioLevels);
  localparam int DepthWidth = $clog2(StackDepth + 1);
  localparam int c_stk_idx_w = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [VecWidth-1:0]    r_irq_id, w_irq_id_nxt;
  logic [PrioWidth-1:0]   r_irq_prio, w_irq_prio_nxt;
  logic [PrioWidth-1:0]   r_level, w_level_nxt;
  logic [DepthWidth-1:0]  r_depth, w_depth_nxt;
  logic                   r_stack_full, w_stack_full_nxt;
  logic [VecSize-1:0]     r_pend_clr, w_pend_clr_nxt;
  logic [PrioWidth-1:0]   r_stack [StackDepth];
  logic                   w_push;

  logic [PrioWidth-1:0]   w_floor;
  logic [VecSize-1:0]     w_elig;
  logic [PrioWidth-1:0]   w_vprio [VecSize];
  logic                   w_win_found;
  logic [VecWidth-1:0]    w_win_id;
  logic [PrioWidth-1:0]   w_win_prio;
  logic                   w_mret_pop;
  logic [c_stk_idx_w-1:0] w_push_idx;
  logic [c_stk_idx_w-1:0] w_top_idx;

  // A vector must beat both the running level and the threshold.
  assign w_floor = (r_level > bus.thresh) ? r_level : bus.thresh;

  for (genvar k = 0; k < VecSize; k++) begin : g_elig
    assign w_vprio[k] = bus.prio[k*PrioWidth +: PrioWidth];
    assign w_elig[k]  = bus.pended[k] & bus.enable[k] & (w_vprio[k] > w_floor);
  end

  // Ascending scan with a strict compare keeps the lowest index on ties.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_win_prio  = '0;
    for (int k = 0; k < VecSize; k++) begin
      if (w_elig[k] && (!w_win_found || (w_vprio[k] > w_win_prio))) begin
        w_win_found = 1'b1;
        w_win_id    = VecWidth'(k);
        w_win_prio  = w_vprio[k];
      end
    end
  end

  assign w_mret_pop = bus.mret && (r_depth != '0);
  assign w_push_idx = c_stk_idx_w'(r_depth);
  assign w_top_idx  = c_stk_idx_w'(r_depth - DepthWidth'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_irq_id_nxt   = r_irq_id;
    w_irq_prio_nxt = r_irq_prio;
    w_level_nxt    = r_level;
    w_depth_nxt    = r_depth;
    w_pend_clr_nxt = '0;
    w_push         = 1'b0;

    if (w_mret_pop) begin
      w_level_nxt = r_stack[w_top_idx];
      w_depth_nxt = r_depth - DepthWidth'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_win_found && !r_stack_full) begin
          w_state_nxt    = S_REQ;
          w_irq_id_nxt   = w_win_id;
          w_irq_prio_nxt = w_win_prio;
        end
      end
      S_REQ: begin
        if (bus.irq_ack) begin
          w_state_nxt    = S_IDLE;
          w_pend_clr_nxt = VecSize'(1) << r_irq_id;
          w_level_nxt    = r_irq_prio;
          if (w_mret_pop) begin
            // The popped entry would be pushed straight back into the same
            // slot. The stack array and depth therefore stay as they are.
            w_depth_nxt = r_depth;
          end else begin
            w_depth_nxt = r_depth + DepthWidth'(1);
            w_push      = 1'b1;
          end
        end else if (!w_elig[r_irq_id]) begin
          w_state_nxt = S_IDLE;
        end else if (w_win_found && (w_win_prio > r_irq_prio)) begin
          w_irq_id_nxt   = w_win_id;
          w_irq_prio_nxt = w_win_prio;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_stack_full_nxt = (w_depth_nxt == DepthWidth'(StackDepth));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_id     <= '0;
      r_irq_prio   <= '0;
      r_level      <= '0;
      r_depth      <= '0;
      r_stack_full <= 1'b0;
      r_pend_clr   <= '0;
    end else begin
      r_irq_id     <= w_irq_id_nxt;
      r_irq_prio   <= w_irq_prio_nxt;
      r_level      <= w_level_nxt;
      r_depth      <= w_depth_nxt;
      r_stack_full <= w_stack_full_nxt;
      r_pend_clr   <= w_pend_clr_nxt;
    end
  end

  // Stack contents are meaningful only below depth, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= r_level;
    end
  end

  assign bus.irq_valid  = (r_state == S_REQ);
  assign bus.irq_id     = r_irq_id;
  assign bus.irq_prio   = r_irq_prio;
  assign bus.pend_clr   = r_pend_clr;
  assign bus.level      = r_level;
  assign bus.depth      = r_depth;
  assign bus.stack_full = r_stack_full;
endmodule
`default_nettype wire
